// File: rtl/regfile_pkg.sv
// Shared register-file constants and writeback request type.
package regfile_pkg;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned XLEN       = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [XLEN-1:0]       rd_data;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin grant generator: searches from rr_ptr upward (wrapping) and
// advances the pointer past the winner.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 3,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NUM_REQ-1:0] i_valid,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_grant_idx,
  output logic               o_grant_valid
);

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] rr_ptr_next;

  always_comb begin
    int unsigned cand;
    o_grant       = '0;
    o_grant_idx   = '0;
    o_grant_valid = 1'b0;
    cand          = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!o_grant_valid && i_valid[IDX_W'(cand)]) begin
        o_grant_valid = 1'b1;
        o_grant_idx   = IDX_W'(cand);
      end
    end
    if (o_grant_valid) o_grant[o_grant_idx] = 1'b1;
  end

  always_comb begin
    rr_ptr_next = rr_ptr;
    if (o_grant_valid) begin
      if (o_grant_idx == IDX_W'(NUM_REQ - 1)) rr_ptr_next = '0;
      else                                    rr_ptr_next = o_grant_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) rr_ptr <= '0;
    else         rr_ptr <= rr_ptr_next;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between writeback units and tracks
// in-flight destination registers for issue hazard checks.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned XLEN    = regfile_pkg::XLEN
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic [NUM_REQ-1:0]              i_req_valid,
  input  logic [NUM_REQ*REG_ADDR_W-1:0]   i_req_rd_addr,
  input  logic [NUM_REQ*XLEN-1:0]         i_req_rd_data,
  output logic [NUM_REQ-1:0]              o_req_ready,
  output logic [REG_ADDR_W-1:0]           o_rd_addr,
  output logic [XLEN-1:0]                 o_rd_data,
  output logic                            o_rd_wren,
  input  logic                            i_issue_valid,
  input  logic [REG_ADDR_W-1:0]           i_issue_rd_addr,
  output logic                            o_issue_stall,
  input  logic [REG_ADDR_W-1:0]           i_rs1_addr,
  input  logic [REG_ADDR_W-1:0]           i_rs2_addr,
  output logic                            o_rs1_busy,
  output logic                            o_rs2_busy
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [REG_ADDR_W-1:0] req_addr [NUM_REQ];
  logic [XLEN-1:0]       req_data [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_addr[g] = i_req_rd_addr[REG_ADDR_W*g +: REG_ADDR_W];
    assign req_data[g] = i_req_rd_data[XLEN*g +: XLEN];
  end

  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_valid       (i_req_valid),
    .o_grant       (o_req_ready),
    .o_grant_idx   (grant_idx),
    .o_grant_valid (grant_valid)
  );

  logic [REG_ADDR_W-1:0] win_addr;
  logic [XLEN-1:0]       win_data;

  assign win_addr = req_addr[grant_idx];
  assign win_data = req_data[grant_idx];

  // x0 writes are consumed but never enable the regfile.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_rd_wren <= 1'b0;
      o_rd_addr <= '0;
      o_rd_data <= '0;
    end else begin
      o_rd_wren <= grant_valid && (win_addr != '0);
      if (grant_valid) begin
        o_rd_addr <= win_addr;
        o_rd_data <= win_data;
      end
    end
  end

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;
  logic                issue_set;

  assign o_rs1_busy    = busy[i_rs1_addr];
  assign o_rs2_busy    = busy[i_rs2_addr];
  assign o_issue_stall = i_issue_valid && busy[i_issue_rd_addr];
  assign issue_set     = i_issue_valid && !o_issue_stall && (i_issue_rd_addr != '0);

  // Clear is applied before set so a coincident set wins.
  always_comb begin
    busy_next = busy;
    if (o_rd_wren) busy_next[o_rd_addr] = 1'b0;
    if (issue_set) busy_next[i_issue_rd_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) busy <= '0;
    else         busy <= busy_next;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with hand-computed expectations.
module tb_regfile_wb_arbiter;
  localparam int unsigned NR = 3;
  localparam int unsigned XL = 32;

  logic            i_clk = 1'b0;
  logic            i_reset;
  logic [NR-1:0]   i_req_valid;
  logic [NR*5-1:0] i_req_rd_addr;
  logic [NR*XL-1:0] i_req_rd_data;
  logic [NR-1:0]   o_req_ready;
  logic [4:0]      o_rd_addr;
  logic [XL-1:0]   o_rd_data;
  logic            o_rd_wren;
  logic            i_issue_valid;
  logic [4:0]      i_issue_rd_addr;
  logic            o_issue_stall;
  logic [4:0]      i_rs1_addr;
  logic [4:0]      i_rs2_addr;
  logic            o_rs1_busy;
  logic            o_rs2_busy;

  int n_checks = 0;
  int n_errors = 0;

  regfile_wb_arbiter #(
    .NUM_REQ (NR),
    .XLEN    (XL)
  ) dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_req_valid     (i_req_valid),
    .i_req_rd_addr   (i_req_rd_addr),
    .i_req_rd_data   (i_req_rd_data),
    .o_req_ready     (o_req_ready),
    .o_rd_addr       (o_rd_addr),
    .o_rd_data       (o_rd_data),
    .o_rd_wren       (o_rd_wren),
    .i_issue_valid   (i_issue_valid),
    .i_issue_rd_addr (i_issue_rd_addr),
    .o_issue_stall   (o_issue_stall),
    .i_rs1_addr      (i_rs1_addr),
    .i_rs2_addr      (i_rs2_addr),
    .o_rs1_busy      (o_rs1_busy),
    .o_rs2_busy      (o_rs2_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic v, input logic [4:0] a, input logic [XL-1:0] d);
    i_req_valid[idx]           = v;
    i_req_rd_addr[5*idx +: 5]  = a;
    i_req_rd_data[XL*idx +: XL] = d;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    step();
    step();
    i_reset = 1'b0;
  endtask

  initial begin
    i_reset         = 1'b0;
    i_req_valid     = '0;
    i_req_rd_addr   = '0;
    i_req_rd_data   = '0;
    i_issue_valid   = 1'b0;
    i_issue_rd_addr = '0;
    i_rs1_addr      = '0;
    i_rs2_addr      = '0;
    #2;
    do_reset();

    // reset state
    check("rst_wren", 64'(o_rd_wren), 64'd0);
    check("rst_addr", 64'(o_rd_addr), 64'd0);
    check("rst_data", 64'(o_rd_data), 64'd0);
    check("rst_ready", 64'(o_req_ready), 64'd0);

    // single request
    set_req(0, 1'b1, 5'd3, 32'hDEADBEEF);
    #1;
    check("single_ready", 64'(o_req_ready), 64'b001);
    step();
    set_req(0, 1'b0, 5'd0, 32'h0);
    #1;
    check("single_wren", 64'(o_rd_wren), 64'd1);
    check("single_addr", 64'(o_rd_addr), 64'd3);
    check("single_data", 64'(o_rd_data), 64'hDEADBEEF);
    step();
    check("single_wren_off", 64'(o_rd_wren), 64'd0);
    check("single_addr_hold", 64'(o_rd_addr), 64'd3);

    // round robin from reset, all continuously valid
    do_reset();
    set_req(0, 1'b1, 5'd10, 32'hA0);
    set_req(1, 1'b1, 5'd11, 32'hB1);
    set_req(2, 1'b1, 5'd12, 32'hC2);
    #1;
    for (int c = 0; c < 6; c++) begin
      check($sformatf("rr_ready_%0d", c), 64'(o_req_ready), 64'(1 << (c % 3)));
      step();
      check($sformatf("rr_addr_%0d", c), 64'(o_rd_addr), 64'(10 + (c % 3)));
      check($sformatf("rr_wren_%0d", c), 64'(o_rd_wren), 64'd1);
    end
    i_req_valid = '0;
    step();
    check("rr_idle_wren", 64'(o_rd_wren), 64'd0);

    // RAW scoreboard on x7
    i_issue_valid = 1'b1; i_issue_rd_addr = 5'd7; i_rs1_addr = 5'd7; i_rs2_addr = 5'd7;
    #1;
    check("raw_stall0", 64'(o_issue_stall), 64'd0);
    check("raw_busy_pre", 64'(o_rs1_busy), 64'd0);
    step();
    i_issue_valid = 1'b0;
    #1;
    check("raw_busy_set", 64'(o_rs1_busy), 64'd1);
    set_req(1, 1'b1, 5'd7, 32'h77);
    #1;
    check("raw_ready", 64'(o_req_ready), 64'b010);
    check("raw_busy_N", 64'(o_rs1_busy), 64'd1);
    step();
    set_req(1, 1'b0, 5'd0, 32'h0);
    #1;
    check("raw_wren_N1", 64'(o_rd_wren), 64'd1);
    check("raw_busy_N1", 64'(o_rs1_busy), 64'd1);
    check("raw_rs2_N1", 64'(o_rs2_busy), 64'd1);
    step();
    check("raw_busy_N2", 64'(o_rs1_busy), 64'd0);
    check("raw_rs2_N2", 64'(o_rs2_busy), 64'd0);

    // WAW stall on x9 (rr_ptr now 2)
    i_issue_valid = 1'b1; i_issue_rd_addr = 5'd9;
    #1;
    check("waw_first", 64'(o_issue_stall), 64'd0);
    step();
    check("waw_stall_a", 64'(o_issue_stall), 64'd1);
    step();
    check("waw_stall_b", 64'(o_issue_stall), 64'd1);
    set_req(2, 1'b1, 5'd9, 32'h99);
    #1;
    check("waw_ready", 64'(o_req_ready), 64'b100);
    check("waw_stall_c", 64'(o_issue_stall), 64'd1);
    step();
    set_req(2, 1'b0, 5'd0, 32'h0);
    #1;
    check("waw_wren", 64'(o_rd_wren), 64'd1);
    check("waw_stall_commit", 64'(o_issue_stall), 64'd1);
    step();
    check("waw_released", 64'(o_issue_stall), 64'd0);
    i_issue_valid = 1'b0;
    i_issue_rd_addr = 5'd0; i_rs1_addr = 5'd0;
    i_issue_valid = 1'b1;
    #1;
    check("x0_issue_stall", 64'(o_issue_stall), 64'd0);
    step();
    check("x0_issue_stall2", 64'(o_issue_stall), 64'd0);
    check("x0_issue_busy", 64'(o_rs1_busy), 64'd0);
    i_issue_valid = 1'b0;

    // x0 writeback with x4 busy (rr_ptr now 0)
    i_issue_valid = 1'b1; i_issue_rd_addr = 5'd4;
    step();
    i_issue_valid = 1'b0;
    i_rs1_addr = 5'd4; i_rs2_addr = 5'd0;
    set_req(2, 1'b1, 5'd0, 32'h1234);
    #1;
    check("x0wb_ready", 64'(o_req_ready), 64'b100);
    step();
    set_req(2, 1'b0, 5'd0, 32'h0);
    #1;
    check("x0wb_wren", 64'(o_rd_wren), 64'd0);
    check("x0wb_addr", 64'(o_rd_addr), 64'd0);
    check("x0wb_data", 64'(o_rd_data), 64'h1234);
    check("x0wb_x4_busy", 64'(o_rs1_busy), 64'd1);
    check("x0wb_x0_busy", 64'(o_rs2_busy), 64'd0);

    // sparse round robin: req0 and req2 only, expect 0,2,0
    set_req(0, 1'b1, 5'd1, 32'h11);
    set_req(2, 1'b1, 5'd2, 32'h22);
    #1;
    check("sparse_g0", 64'(o_req_ready), 64'b001);
    step();
    check("sparse_g1", 64'(o_req_ready), 64'b100);
    check("sparse_out0", 64'(o_rd_addr), 64'd1);
    step();
    check("sparse_g2", 64'(o_req_ready), 64'b001);
    check("sparse_out1", 64'(o_rd_addr), 64'd2);
    step();
    i_req_valid = '0;

    // asynchronous reset mid-stream (rr_ptr now 1, x4 still busy)
    i_issue_valid = 1'b1; i_issue_rd_addr = 5'd5;
    step();
    i_issue_valid = 1'b0;
    i_rs1_addr = 5'd5; i_rs2_addr = 5'd4;
    set_req(0, 1'b1, 5'd5, 32'h55);
    #1;
    check("mid_ready", 64'(o_req_ready), 64'b001);
    step();
    set_req(0, 1'b0, 5'd0, 32'h0);
    #1;
    check("mid_wren", 64'(o_rd_wren), 64'd1);
    check("mid_x5_busy", 64'(o_rs1_busy), 64'd1);
    check("mid_x4_busy", 64'(o_rs2_busy), 64'd1);
    #1;
    i_reset = 1'b1;
    #1;
    check("arst_wren", 64'(o_rd_wren), 64'd0);
    check("arst_addr", 64'(o_rd_addr), 64'd0);
    check("arst_data", 64'(o_rd_data), 64'd0);
    check("arst_x5", 64'(o_rs1_busy), 64'd0);
    check("arst_x4", 64'(o_rs2_busy), 64'd0);
    step();
    i_reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
